decoder_scheduler: RTL and testbench

Round-robin scheduler that shares one turbo Decoder instance between NUM_REQ frame requesters. It accepts an 84-bit coded frame from the granted requester and streams it into the Decoder as BEATS consecutive 21-bit beats under start. It then waits for done, with a timeout, and returns the 5-bit decoded result tagged with the requester ID. It sits between the frame sources and the Decoder's start_i/data_i/data_o/done_o interface.

---
 rtl/decoder_scheduler.sv | 139 +++++++++++++
 tb/tb_decoder_scheduler.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scheduler.sv
// rtl/decoder_scheduler.sv - round-robin scheduler sharing one turbo decoder between frame requesters
module decoder_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int BEATS   = 4,
   parameter int BEAT_W  = 21,
   parameter int OUT_W   = 5,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                         clk_p_i,
   input  logic                         reset_p_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   input  logic [NUM_REQ*BEATS*BEAT_W-1:0] req_frame_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   output logic                         dec_start_o,
   output logic [BEAT_W-1:0]            dec_data_o,
   input  logic [OUT_W-1:0]             dec_data_i,
   input  logic                         dec_done_i,
   output logic                         rsp_valid_o,
   output logic [OUT_W-1:0]             rsp_data_o,
   output logic [ID_W-1:0]              rsp_id_o,
   output logic                         rsp_timeout_o,
   input  logic                         rsp_ready_i,
   output logic                         busy_o
);

   localparam int FRAME_W = BEATS * BEAT_W;
   localparam int BC_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     id_q;
   logic [BC_W-1:0]     beat_cnt;
   logic [TC_W-1:0]     tmo_cnt;
   logic [FRAME_W-1:0]  frame_q;

   logic                grant_any;
   logic [ID_W-1:0]     grant_idx;
   logic [FRAME_W-1:0]  sel_frame;
   int                  cand;

   // Search starts at the round-robin pointer and wraps modulo NUM_REQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int r = 0; r < NUM_REQ; r++) begin
            if (!grant_any && r == cand && req_valid_i[r]) begin
               grant_any = 1'b1;
               grant_idx = ID_W'(r);
            end
         end
      end
   end

   always_comb begin
      sel_frame   = '0;
      req_ready_o = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (grant_idx == ID_W'(r)) sel_frame = req_frame_i[r*FRAME_W +: FRAME_W];
         req_ready_o[r] = (state == IDLE) && grant_any && !reset_p_i && (grant_idx == ID_W'(r));
      end
   end

   assign busy_o = (state != IDLE);

   // frame_q is a shift register: the next beat to send always sits in its low bits.
   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         id_q          <= '0;
         beat_cnt      <= '0;
         tmo_cnt       <= '0;
         frame_q       <= '0;
         dec_start_o   <= 1'b0;
         dec_data_o    <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_data_o    <= '0;
         rsp_id_o      <= '0;
         rsp_timeout_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  frame_q     <= sel_frame >> BEAT_W;
                  dec_data_o  <= sel_frame[BEAT_W-1:0];
                  dec_start_o <= 1'b1;
                  id_q        <= grant_idx;
                  rr_ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                  beat_cnt    <= '0;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               if (beat_cnt == BC_W'(BEATS - 1)) begin
                  dec_start_o <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= WAIT;
               end else begin
                  beat_cnt   <= beat_cnt + BC_W'(1);
                  dec_data_o <= frame_q[BEAT_W-1:0];
                  frame_q    <= frame_q >> BEAT_W;
               end
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + TC_W'(1);
               if (dec_done_i) begin
                  rsp_data_o    <= dec_data_i;
                  rsp_timeout_o <= 1'b0;
                  rsp_id_o      <= id_q;
                  rsp_valid_o   <= 1'b1;
                  state         <= RESP;
               end else if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
                  rsp_data_o    <= '0;
                  rsp_timeout_o <= 1'b1;
                  rsp_id_o      <= id_q;
                  rsp_valid_o   <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_scheduler.sv
// tb/tb_decoder_scheduler.sv - directed scoreboard bench for decoder_scheduler
module tb_decoder_scheduler;

   localparam int NUM_REQ = 2;
   localparam int BEATS   = 4;
   localparam int BEAT_W  = 21;
   localparam int OUT_W   = 5;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 1023;
   localparam int FRAME_W = BEATS * BEAT_W;

   typedef struct {
      logic [ID_W-1:0]  id;
      logic [OUT_W-1:0] data;
      logic             tmo;
   } exp_t;

   logic                          clk = 1'b0;
   logic                          reset_p_i;
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ*FRAME_W-1:0]    req_frame_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic                          dec_start_o;
   logic [BEAT_W-1:0]             dec_data_o;
   logic [OUT_W-1:0]              dec_data_i = '0;
   logic                          dec_done_i = 1'b0;
   logic                          rsp_valid_o;
   logic [OUT_W-1:0]              rsp_data_o;
   logic [ID_W-1:0]               rsp_id_o;
   logic                          rsp_timeout_o;
   logic                          rsp_ready_i;
   logic                          busy_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // decoder model state
   int               dly = 10;
   bit               inject = 1'b0;
   logic [OUT_W-1:0] res_q[$];
   int               res_rd = 0;
   logic [BEAT_W-1:0] beat_q[$];
   int               run_q[$];
   int               cur_run = 0;
   int               dly_cnt = 0;
   logic [OUT_W-1:0] pend_res = '0;

   exp_t exp_q[$];
   int   beat_rd = 0;
   int   run_rd = 0;
   int   exp_ptr = 0;

   decoder_scheduler #(
      .NUM_REQ(NUM_REQ), .BEATS(BEATS), .BEAT_W(BEAT_W),
      .OUT_W(OUT_W), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_p_i(clk),
      .reset_p_i(reset_p_i),
      .req_valid_i(req_valid_i),
      .req_frame_i(req_frame_i),
      .req_ready_o(req_ready_o),
      .dec_start_o(dec_start_o),
      .dec_data_o(dec_data_o),
      .dec_data_i(dec_data_i),
      .dec_done_i(dec_done_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o(rsp_data_o),
      .rsp_id_o(rsp_id_o),
      .rsp_timeout_o(rsp_timeout_o),
      .rsp_ready_i(rsp_ready_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Decoder model: logs beats, answers dly cycles after the last beat when a result is queued.
   always @(posedge clk) begin
      if (reset_p_i) begin
         cur_run = 0;
         dly_cnt = 0;
         dec_done_i <= 1'b0;
      end else begin
         dec_done_i <= 1'b0;
         if (dly_cnt != 0) begin
            if (dly_cnt == 1) begin
               dec_done_i <= 1'b1;
               dec_data_i <= pend_res;
            end
            dly_cnt = dly_cnt - 1;
         end
         if (dec_start_o) begin
            beat_q.push_back(dec_data_o);
            cur_run = cur_run + 1;
            if (inject && cur_run == 2) begin
               dec_done_i <= 1'b1;
               dec_data_i <= 5'h1f;
            end
            if (cur_run == BEATS && res_rd < res_q.size()) begin
               pend_res = res_q[res_rd];
               res_rd = res_rd + 1;
               dly_cnt = dly - 1;
            end
         end else if (cur_run != 0) begin
            run_q.push_back(cur_run);
            cur_run = 0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [FRAME_W-1:0] rnd84();
      logic [95:0] v;
      v = {$urandom, $urandom, $urandom};
      return v[FRAME_W-1:0];
   endfunction

   task automatic wait_ready(input string tag, output int g, output int t);
      int n = 0;
      #1;
      while (req_ready_o === '0 && n < 100) begin
         nxt();
         n++;
      end
      chk({tag, "_grant_seen"}, (req_ready_o !== '0), 1);
      chk({tag, "_onehot"}, $onehot(req_ready_o), 1);
      g = req_ready_o[1] ? 1 : 0;
      t = cyc;
   endtask

   task automatic wait_rsp(input string tag, input int t0, input int lat);
      int n = 0;
      exp_t e;
      while (rsp_valid_o !== 1'b1 && n < 1200) begin
         nxt();
         n++;
      end
      chk({tag, "_rsp_seen"}, rsp_valid_o, 1);
      chk({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
      if (rsp_valid_o === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_latency"}, cyc - t0, lat);
         chk({tag, "_rsp_id"}, rsp_id_o, e.id);
         chk({tag, "_rsp_data"}, rsp_data_o, e.data);
         chk({tag, "_rsp_tmo"}, rsp_timeout_o, e.tmo);
      end
   endtask

   task automatic chk_beats(input string tag, input logic [FRAME_W-1:0] f);
      chk({tag, "_beats_logged"}, (beat_q.size() - beat_rd >= BEATS), 1);
      for (int k = 0; k < BEATS; k++) begin
         if (beat_rd < beat_q.size()) begin
            chk({tag, "_beat"}, beat_q[beat_rd], f[k*BEAT_W +: BEAT_W]);
            beat_rd++;
         end
      end
      chk({tag, "_run_logged"}, (run_rd < run_q.size()), 1);
      if (run_rd < run_q.size()) begin
         chk({tag, "_start_run_len"}, run_q[run_rd], BEATS);
         run_rd++;
      end
   endtask

   initial begin
      int g, t, stale;
      logic [FRAME_W-1:0] f0, f1, saved;
      logic [OUT_W-1:0] r;

      reset_p_i   = 1'b1;
      req_valid_i = '0;
      req_frame_i = '0;
      rsp_ready_i = 1'b1;
      repeat (3) nxt();
      req_valid_i = 2'b11;
      #1;
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_dec_start", dec_start_o, 0);
      chk("rst_dec_data", dec_data_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_data", rsp_data_o, 0);
      chk("rst_rsp_id", rsp_id_o, 0);
      chk("rst_rsp_tmo", rsp_timeout_o, 0);
      chk("rst_busy", busy_o, 0);
      req_valid_i = '0;
      nxt();
      reset_p_i = 1'b0;
      nxt();

      // single frame from requester 0, done 10 cycles after last beat
      f0 = 84'h0_F2CF_F64F_83C1_9C58;
      req_frame_i[FRAME_W-1:0] = f0;
      req_valid_i = 2'b01;
      res_q.push_back(5'd19);
      dly = 10;
      wait_ready("single", g, t);
      chk("single_ready_val", req_ready_o, 2'b01);
      exp_q.push_back('{id: 2'd0, data: 5'd19, tmo: 1'b0});
      exp_ptr = 1;
      for (int k = 0; k < BEATS; k++) begin
         nxt();
         req_valid_i = '0;
         #1;
         chk("single_start", dec_start_o, 1);
         chk("single_beat_out", dec_data_o, f0[k*BEAT_W +: BEAT_W]);
         chk("single_ready_load", req_ready_o, 0);
      end
      nxt();
      chk("single_start_drop", dec_start_o, 0);
      chk("single_data_hold", dec_data_o, f0[3*BEAT_W +: BEAT_W]);
      chk("single_busy", busy_o, 1);
      wait_rsp("single", t, 15);
      chk_beats("single", f0);
      nxt();
      chk("single_rsp_clear", rsp_valid_o, 0);
      chk("single_idle", busy_o, 0);

      // backpressure with requester 1
      rsp_ready_i = 1'b0;
      f1 = rnd84();
      req_frame_i[2*FRAME_W-1:FRAME_W] = f1;
      req_valid_i = 2'b10;
      res_q.push_back(5'd7);
      dly = 5;
      wait_ready("bp", g, t);
      chk("bp_grant", g, exp_ptr);
      exp_q.push_back('{id: 2'd1, data: 5'd7, tmo: 1'b0});
      nxt();
      req_valid_i = '0;
      wait_rsp("bp", t, 10);
      req_valid_i = 2'b11;
      for (int i = 0; i < 20; i++) begin
         nxt();
         chk("bp_valid_hold", rsp_valid_o, 1);
         chk("bp_data_hold", rsp_data_o, 5'd7);
         chk("bp_id_hold", rsp_id_o, 1);
         chk("bp_tmo_hold", rsp_timeout_o, 0);
         chk("bp_no_grant", req_ready_o, 0);
         chk("bp_busy", busy_o, 1);
      end
      rsp_ready_i = 1'b1;
      #1;
      chk("bp_no_grant_hs", req_ready_o, 0);
      nxt();
      chk("bp_rsp_clear", rsp_valid_o, 0);
      chk("bp_next_grant", req_ready_o, 2'b01);
      req_valid_i = '0;
      #1;
      chk("bp_withdraw", req_ready_o, 0);
      exp_ptr = 0;
      chk_beats("bp", f1);

      // round robin with both requesters continuously valid
      req_frame_i = {rnd84(), rnd84()};
      req_valid_i = 2'b11;
      for (int f = 0; f < 4; f++) begin
         r = OUT_W'(3 + 5 * f);
         res_q.push_back(r);
         dly = 2 + 3 * f;
         wait_ready("rr", g, t);
         chk("rr_grant_order", g, f % 2);
         chk("rr_grant_ptr", g, exp_ptr);
         exp_ptr = (g + 1) % NUM_REQ;
         exp_q.push_back('{id: ID_W'(g), data: r, tmo: 1'b0});
         saved = (g == 1) ? req_frame_i[2*FRAME_W-1:FRAME_W] : req_frame_i[FRAME_W-1:0];
         nxt();
         if (g == 1) req_frame_i[2*FRAME_W-1:FRAME_W] = rnd84();
         else req_frame_i[FRAME_W-1:0] = rnd84();
         wait_rsp("rr", t, BEATS + dly + 1);
         chk_beats("rr", saved);
         if (f == 3) req_valid_i = '0;
      end

      // spurious done during LOAD must be ignored
      nxt();
      inject = 1'b1;
      f0 = rnd84();
      req_frame_i[FRAME_W-1:0] = f0;
      req_valid_i = 2'b01;
      res_q.push_back(5'd22);
      dly = 6;
      wait_ready("inject", g, t);
      chk("inject_grant", g, exp_ptr);
      exp_ptr = 1;
      exp_q.push_back('{id: 2'd0, data: 5'd22, tmo: 1'b0});
      nxt();
      req_valid_i = '0;
      wait_rsp("inject", t, 11);
      inject = 1'b0;
      chk_beats("inject", f0);

      // decoder never answers
      nxt();
      f1 = rnd84();
      req_frame_i[2*FRAME_W-1:FRAME_W] = f1;
      req_valid_i = 2'b10;
      wait_ready("timeout", g, t);
      chk("timeout_grant", g, exp_ptr);
      exp_ptr = 0;
      exp_q.push_back('{id: 2'd1, data: 5'd0, tmo: 1'b1});
      nxt();
      req_valid_i = '0;
      wait_rsp("timeout", t, BEATS + 1 + TIMEOUT);
      chk_beats("timeout", f1);

      // reset during beat 2 of LOAD
      nxt();
      f0 = rnd84();
      req_frame_i[FRAME_W-1:0] = f0;
      req_valid_i = 2'b01;
      wait_ready("mid", g, t);
      chk("mid_grant", g, 0);
      nxt();
      req_valid_i = '0;
      nxt();
      nxt();
      chk("mid_start_before", dec_start_o, 1);
      req_valid_i = 2'b11;
      reset_p_i = 1'b1;
      #1;
      chk("mid_rst_start", dec_start_o, 0);
      chk("mid_rst_ready", req_ready_o, 0);
      chk("mid_rst_rsp_valid", rsp_valid_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      nxt();
      nxt();
      res_q.push_back(5'd9);
      dly = 4;
      exp_ptr = 0;
      beat_rd = beat_q.size();
      run_rd = run_q.size();
      reset_p_i = 1'b0;
      wait_ready("post_rst", g, t);
      chk("post_rst_grant", g, exp_ptr);
      exp_q.push_back('{id: 2'd0, data: 5'd9, tmo: 1'b0});
      saved = req_frame_i[FRAME_W-1:0];
      nxt();
      req_valid_i = '0;
      wait_rsp("post_rst", t, BEATS + 4 + 1);
      chk_beats("post_rst", saved);
      stale = 0;
      for (int i = 0; i < 30; i++) begin
         nxt();
         if (rsp_valid_o !== 1'b0) stale++;
      end
      chk("no_stale_rsp", stale, 0);
      chk("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
